// File: rtl/vs_pkg.sv
// Shared constants and types for the VS10xx SCI control slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: SCI opcode/register addresses, mode words, FSM state and frame-kind enums, frame builder.
package vs_pkg;

  localparam int FRAME_BITS = 32;

  // SCI write frame fields
  localparam logic [7:0] SCI_WRITE  = 8'h02;
  localparam logic [7:0] SCI_MODE   = 8'h00;
  localparam logic [7:0] SCI_CLOCKF = 8'h03;
  localparam logic [7:0] SCI_VOL    = 8'h0B;

  // SCI_MODE values: SM_SDINEW alone, and SM_SDINEW|SM_RESET
  localparam logic [15:0] MODE_NORMAL  = 16'h0800;
  localparam logic [15:0] MODE_SOFTRST = 16'h0804;

  typedef enum logic [2:0] {
    S_HWRST,
    S_WAITRDY,
    S_INIT,
    S_IDLE,
    S_DREQ,
    S_SHIFT,
    S_GAP,
    S_SONGWAIT
  } state_t;

  // Which register write the next/current frame carries
  typedef enum logic [1:0] {
    K_MODE,
    K_CLOCKF,
    K_VOL,
    K_SOFTRST
  } kind_t;

  function automatic logic [FRAME_BITS-1:0] sci_frame(input logic [7:0] addr,
                                                      input logic [15:0] data);
    return {SCI_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/vs_sci_ctrl_spi_tx32.sv
// Write-only SPI mode-0 shifter for one 32-bit SCI frame, MSB first.
// Latency: XCS falls the cycle after i_load; XCS-low lasts 66 half-periods; o_done pulses as XCS rises.
// Backpressure: i_load is ignored while a frame is in flight; the caller waits for o_done.
// Ports: CLK/RST (sync, active-low); i_load/i_frame start a frame; o_sclk/o_mosi/o_xcs drive the bus; o_done ends it.
module spi_tx32 #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_load,
  input  logic [31:0] i_frame,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_xcs,
  output logic        o_done
);
  import vs_pkg::*;

  // Half-period slots while XCS is low: slot 0 is the setup slot before the
  // first rising edge, odd slots 1..63 are SCLK high, even slots 2..64 start
  // with a falling edge (MOSI advances there), slot 65 is the trailing guard.
  localparam int NPH   = 2 * FRAME_BITS + 2;
  localparam int PH_W  = $clog2(NPH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]      r_div;
  logic [PH_W-1:0]       r_phase;
  logic [FRAME_BITS-1:0] r_sh;
  logic                  r_active;
  logic                  r_sclk;
  logic                  r_xcs;
  logic                  r_done;

  logic                  w_half_end;
  logic [PH_W-1:0]       w_phase_nxt;

  assign w_half_end  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_phase_nxt = r_phase + PH_W'(1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_div    <= '0;
      r_phase  <= '0;
      r_sh     <= '0;
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_xcs    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (i_load) begin
          r_active <= 1'b1;
          r_xcs    <= 1'b0;
          r_sh     <= i_frame;
          r_div    <= '0;
          r_phase  <= '0;
          r_sclk   <= 1'b0;
        end
      end else if (!w_half_end) begin
        r_div <= r_div + DIV_W'(1);
      end else begin
        r_div <= '0;
        if (r_phase == PH_W'(NPH - 1)) begin
          r_active <= 1'b0;
          r_xcs    <= 1'b1;
          r_done   <= 1'b1;
          r_phase  <= '0;
        end else begin
          r_phase <= w_phase_nxt;
          r_sclk  <= w_phase_nxt[0] && (w_phase_nxt <= PH_W'(2 * FRAME_BITS - 1));
          // Advance MOSI on each falling edge, never while SCLK is high
          if (!w_phase_nxt[0] && (w_phase_nxt <= PH_W'(2 * FRAME_BITS)))
            r_sh <= {r_sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_sh[FRAME_BITS-1];
  assign o_xcs  = r_xcs;
  assign o_done = r_done;

endmodule

// File: rtl/vs_sci_ctrl.sv
// VS10xx SCI sequencer: hardware reset, init writes, volume updates and song-change soft resets.
// Latency: one frame (66*CLK_DIV cycles of XCS low) plus GAP_CYC per register write, after DREQ.
// Backpressure: every frame waits for DREQ=1; input changes during a frame coalesce into the next write.
// Ports: CLK/RST (sync, active-low); vol/CURRENT requests; DREQ decoder ready;
//        XRST/XCS/SCLK/MOSI decoder pins; init_done, busy, song_start status to neighbours.
module vs_sci_ctrl #(
  parameter int          CLK_DIV    = 4,       // SCLK half-period in CLK cycles, >= 2
  parameter int          HWRST_CYC  = 100000,
  parameter int          GAP_CYC    = 8,
  parameter logic [15:0] CLOCKF_VAL = 16'h9800
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] vol,
  input  logic [2:0]  CURRENT,
  input  logic        DREQ,
  output logic        XRST,
  output logic        XCS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        init_done,
  output logic        busy,
  output logic        song_start
);
  import vs_pkg::*;

  // One counter serves both timed states; it clears on every state change.
  localparam int CNT_MAX = (HWRST_CYC > GAP_CYC) ? HWRST_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_init_idx;
  kind_t              r_kind;
  logic [15:0]        r_vol_sent;
  logic [2:0]         r_cur_sent;
  logic               r_vol_force;
  logic               r_init_done;
  logic               r_song_start;

  logic               w_song_req;
  logic               w_vol_req;
  logic               w_hw_end;
  logic               w_gap_end;
  logic               w_load;
  logic               w_spi_done;
  logic [31:0]        w_frame;

  assign w_song_req = (CURRENT != r_cur_sent);
  // A soft reset restores the decoder's default volume, so r_vol_force
  // demands a VOL rewrite even when vol itself has not moved.
  assign w_vol_req  = r_vol_force || (vol != r_vol_sent);
  // Counting starts at the first cycle out of reset, so XRST stays low for
  // exactly HWRST_CYC cycles after release.
  assign w_hw_end   = (r_cnt == CNT_W'(HWRST_CYC));
  assign w_gap_end  = (r_cnt == CNT_W'(GAP_CYC - 1));
  assign w_load     = (r_state == S_DREQ) && DREQ;

  // Frame contents are built from the live inputs so the load cycle is the
  // single sampling point for vol.
  always_comb begin
    w_frame = sci_frame(SCI_VOL, vol);
    case (r_kind)
      K_MODE:    w_frame = sci_frame(SCI_MODE, MODE_NORMAL);
      K_CLOCKF:  w_frame = sci_frame(SCI_CLOCKF, CLOCKF_VAL);
      K_SOFTRST: w_frame = sci_frame(SCI_MODE, MODE_SOFTRST);
      default:   w_frame = sci_frame(SCI_VOL, vol);
    endcase
  end

  spi_tx32 #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_load),
    .i_frame (w_frame),
    .o_sclk  (SCLK),
    .o_mosi  (MOSI),
    .o_xcs   (XCS),
    .o_done  (w_spi_done)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_HWRST;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HWRST:    if (w_hw_end) w_state_nxt = S_WAITRDY;
      S_WAITRDY:  if (DREQ) w_state_nxt = S_INIT;
      S_INIT:     w_state_nxt = (r_init_idx == 2'd3) ? S_IDLE : S_DREQ;
      S_IDLE:     if (w_song_req || w_vol_req) w_state_nxt = S_DREQ;
      S_DREQ:     if (DREQ) w_state_nxt = S_SHIFT;
      S_SHIFT:    if (w_spi_done) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_gap_end) begin
          if (r_kind == K_SOFTRST) w_state_nxt = S_SONGWAIT;
          else if (r_init_done)    w_state_nxt = S_IDLE;
          else                     w_state_nxt = S_INIT;
        end
      end
      S_SONGWAIT: if (DREQ) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_HWRST;
    endcase
  end

  // Outputs
  always_comb begin
    XRST = (r_state != S_HWRST);
    busy = (r_state != S_IDLE) || w_song_req || w_vol_req;
  end

  assign init_done  = r_init_done;
  assign song_start = r_song_start;

  // Counters, shadows and frame selection
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt        <= '0;
      r_init_idx   <= 2'd0;
      r_kind       <= K_MODE;
      r_vol_sent   <= 16'h0000;
      r_cur_sent   <= 3'd0;
      r_vol_force  <= 1'b0;
      r_init_done  <= 1'b0;
      r_song_start <= 1'b0;
    end else begin
      r_song_start <= 1'b0;

      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == S_HWRST || r_state == S_GAP)
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_INIT: begin
          case (r_init_idx)
            2'd0: r_kind <= K_MODE;
            2'd1: r_kind <= K_CLOCKF;
            2'd2: r_kind <= K_VOL;
            default: begin
              r_init_done <= 1'b1;
              r_cur_sent  <= CURRENT;
            end
          endcase
        end
        S_IDLE: begin
          if (w_song_req)     r_kind <= K_SOFTRST;
          else if (w_vol_req) r_kind <= K_VOL;
        end
        S_DREQ: begin
          if (DREQ) begin
            // Shadows record exactly what goes on the wire at load
            if (r_kind == K_VOL) begin
              r_vol_sent  <= vol;
              r_vol_force <= 1'b0;
            end
            if (r_kind == K_SOFTRST) r_cur_sent <= CURRENT;
          end
        end
        S_GAP: begin
          if (w_gap_end && !r_init_done) r_init_idx <= r_init_idx + 2'd1;
        end
        S_SONGWAIT: begin
          if (DREQ) begin
            r_song_start <= 1'b1;
            r_vol_force  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vs_sci_ctrl.sv
// Scoreboard bench for vs_sci_ctrl: stimulus pushes expected SCI frames, a bus monitor decodes and pops them.
// Latency: n/a (testbench).
// Backpressure: DREQ driven by the bench, optionally with random low cycles.
module tb_vs_sci_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int HWRST_CYC   = 20;
  localparam int GAP_CYC     = 8;
  localparam int XCS_LOW_CYC = 33 * 2 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] vol = 16'h4040;
  logic [2:0]  CURRENT = 3'd0;
  logic        dreq_stim = 1'b1;
  logic        noise_en = 1'b0;
  logic        noise_bit = 1'b1;
  logic        DREQ;
  logic        XRST, XCS, SCLK, MOSI, init_done, busy, song_start;

  assign DREQ = dreq_stim & (noise_bit | ~noise_en);

  vs_sci_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .HWRST_CYC  (HWRST_CYC),
    .GAP_CYC    (GAP_CYC),
    .CLOCKF_VAL (16'h9800)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .vol        (vol),
    .CURRENT    (CURRENT),
    .DREQ       (DREQ),
    .XRST       (XRST),
    .XCS        (XCS),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .init_done  (init_done),
    .busy       (busy),
    .song_start (song_start)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int frames_started = 0;
  int frames_done    = 0;
  int ss_count       = 0;

  logic        mon_active = 1'b0;
  int          mon_bits   = 0;
  int          mon_low    = 0;
  logic [31:0] mon_frame  = '0;
  logic        mon_unstable = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_ss   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame(input logic [7:0] addr, input logic [15:0] data);
    return {8'h02, addr, data};
  endfunction

  // Bus monitor: decodes frames on rising SCLK and scores them against exp_q
  always @(negedge CLK) begin
    logic [31:0] e;
    if (!RST) begin
      mon_active = 1'b0;
      mon_bits   = 0;
    end else if (!XCS) begin
      if (!mon_active) begin
        mon_active   = 1'b1;
        mon_bits     = 0;
        mon_low      = 0;
        mon_frame    = '0;
        mon_unstable = 1'b0;
        frames_started++;
      end
      mon_low++;
      if (SCLK && !prev_sclk) begin
        mon_frame = {mon_frame[30:0], MOSI};
        mon_bits++;
      end else if (SCLK && (MOSI !== prev_mosi)) begin
        mon_unstable = 1'b1;
      end
    end else if (mon_active) begin
      mon_active = 1'b0;
      frames_done++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_frame);
      end else begin
        e = exp_q.pop_front();
        chk("frame_value", mon_frame, e);
      end
      chk("frame_bits", mon_bits, 32);
      chk("xcs_low_cycles", mon_low, XCS_LOW_CYC);
      chk("mosi_stable_while_sclk_high", {31'd0, mon_unstable}, 32'd0);
      mon_bits = 0;
    end
    if (song_start) begin
      ss_count++;
      chk("song_start_single_cycle", {31'd0, prev_ss}, 32'd0);
    end
    prev_sclk = SCLK;
    prev_mosi = MOSI;
    prev_ss   = song_start;
  end

  // Random DREQ dropouts, only gated in while noise_en is set
  always @(negedge CLK) noise_bit = ($urandom_range(0, 3) != 0);

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!busy) break;
    end
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_xcs(input logic level, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (XCS == level) break;
    end
    chk(name, {31'd0, XCS}, {31'd0, level});
  endtask

  task automatic wait_bits(input int n, input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (mon_bits >= n) break;
    end
    chk(name, {31'd0, (mon_bits >= n)}, 32'd1);
  endtask

  task automatic reset_and_init(input string name);
    int lowcnt;
    @(negedge CLK);
    RST = 1'b0;
    tick(3);
    chk({name, "_rst_xrst"}, {31'd0, XRST}, 32'd0);
    chk({name, "_rst_xcs"}, {31'd0, XCS}, 32'd1);
    chk({name, "_rst_sclk"}, {31'd0, SCLK}, 32'd0);
    chk({name, "_rst_mosi"}, {31'd0, MOSI}, 32'd0);
    chk({name, "_rst_init_done"}, {31'd0, init_done}, 32'd0);
    chk({name, "_rst_busy"}, {31'd0, busy}, 32'd1);
    chk({name, "_rst_song_start"}, {31'd0, song_start}, 32'd0);
    exp_q.push_back(frame(8'h00, 16'h0800));
    exp_q.push_back(frame(8'h03, 16'h9800));
    exp_q.push_back(frame(8'h0B, vol));
    RST = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (XRST) break;
      lowcnt++;
    end
    chk({name, "_xrst_low_cycles"}, lowcnt, HWRST_CYC);
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (init_done) break;
    end
    chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    chk({name, "_busy_after_init"}, {31'd0, busy}, 32'd0);
    chk({name, "_init_frames_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int fd0, fs0, ss0, exp_ss, k;
    logic [15:0] m_vol, nv;
    logic [2:0]  m_cur, nc;

    // 1: power-up sequence with vol=4040
    reset_and_init("t1");

    // 2: single volume change
    fd0 = frames_done;
    @(negedge CLK);
    vol = 16'h3030;
    exp_q.push_back(frame(8'h0B, 16'h3030));
    wait_idle(2000, "t2");
    chk("t2_frame_count", frames_done - fd0, 1);

    // 3: song change held off by DREQ, then held off again before song_start
    ss0 = ss_count;
    fs0 = frames_started;
    @(negedge CLK);
    dreq_stim = 1'b0;
    CURRENT   = 3'd5;
    exp_q.push_back(frame(8'h00, 16'h0804));
    tick(40);
    chk("t3_no_xcs_while_dreq_low", frames_started, fs0);
    dreq_stim = 1'b1;
    wait_xcs(1'b0, 100, "t3_song_frame_start");
    wait_xcs(1'b1, 400, "t3_song_frame_end");
    dreq_stim = 1'b0;
    tick(GAP_CYC + 50);
    chk("t3_no_song_start_before_dreq", ss_count, ss0);
    chk("t3_no_frame_before_dreq", frames_started, fs0 + 1);
    exp_q.push_back(frame(8'h0B, vol));
    dreq_stim = 1'b1;
    @(negedge CLK);
    chk("t3_song_start_pulse", {31'd0, song_start}, 32'd1);
    @(negedge CLK);
    chk("t3_song_start_width", {31'd0, song_start}, 32'd0);
    wait_idle(2000, "t3");

    // 4: vol and CURRENT change together -> song first, then one VOL
    ss0 = ss_count;
    fd0 = frames_done;
    nv = 16'($urandom) | 16'h0001;
    nc = CURRENT + 3'($urandom_range(1, 7));
    exp_q.push_back(frame(8'h00, 16'h0804));
    exp_q.push_back(frame(8'h0B, nv));
    @(negedge CLK);
    vol = nv;
    CURRENT = nc;
    wait_idle(3000, "t4");
    tick(300);
    chk("t4_song_start_count", ss_count - ss0, 1);
    chk("t4_frame_count", frames_done - fd0, 2);

    // 5: volume stepped during an in-flight frame coalesces to the last value
    fd0 = frames_done;
    @(negedge CLK);
    vol = 16'h4040;
    exp_q.push_back(frame(8'h0B, 16'h4040));
    wait_xcs(1'b0, 200, "t5_frame_start");
    wait_bits(5, "t5_reach_bit5");
    vol = 16'h3030;
    wait_bits(20, "t5_reach_bit20");
    vol = 16'h2020;
    exp_q.push_back(frame(8'h0B, 16'h2020));
    wait_idle(3000, "t5");
    tick(300);
    chk("t5_frame_count", frames_done - fd0, 2);

    // 7: random requests against a request-level model, with DREQ dropouts
    noise_en = 1'b1;
    m_vol = vol;
    m_cur = CURRENT;
    for (int it = 0; it < 6; it++) begin
      k  = $urandom_range(0, 2);
      nv = m_vol;
      nc = m_cur;
      if (k != 1) nv = 16'($urandom);
      if (k != 0) nc = 3'($urandom_range(0, 7));
      exp_ss = 0;
      if (nc != m_cur) begin
        exp_q.push_back(frame(8'h00, 16'h0804));
        exp_q.push_back(frame(8'h0B, nv));
        exp_ss = 1;
      end else if (nv != m_vol) begin
        exp_q.push_back(frame(8'h0B, nv));
      end
      ss0 = ss_count;
      @(negedge CLK);
      vol = nv;
      CURRENT = nc;
      wait_idle(4000, "t7");
      chk("t7_song_start_count", ss_count - ss0, exp_ss);
      m_vol = nv;
      m_cur = nc;
    end
    noise_en = 1'b0;

    // 6: reset during a frame aborts it and restarts init
    @(negedge CLK);
    vol = (vol == 16'h5A5A) ? 16'hA5A5 : 16'h5A5A;
    wait_xcs(1'b0, 200, "t6_frame_start");
    wait_bits(17, "t6_reach_bit17");
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_abort_xcs", {31'd0, XCS}, 32'd1);
    chk("t6_abort_sclk", {31'd0, SCLK}, 32'd0);
    chk("t6_abort_xrst", {31'd0, XRST}, 32'd0);
    chk("t6_abort_queue_empty", exp_q.size(), 0);
    reset_and_init("t6");

    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at 600000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
